// File: rtl/qoi_pkg.sv
// qoi_pkg: shared constants and types for the QOI decode front end.
//   - QOI chunk opcodes (8-bit tags and the 2-bit tag mask)
//   - file magic "qoif", header length, maximum chunk length
//   - window FSM state encoding
package qoi_pkg;

  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
  localparam logic [7:0] QOI_OP_MASK2 = 8'hC0;

  // Element 0 is the first byte on the wire ('q').
  localparam logic [3:0][7:0] QOI_MAGIC = {8'h66, 8'h69, 8'h6F, 8'h71};

  localparam int QOI_HDR_LEN   = 14;
  localparam int QOI_MAX_CHUNK = 5;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } qoi_state_e;

endpackage

// File: rtl/qoi_hdr_parser.sv
// qoi_hdr_parser: counts the 14 QOI header bytes, checks the magic and
// captures the big-endian image fields. Built only with QOI_HEADER_SKIP_EN.
//   clk, rst        : clock, synchronous active-high reset
//   byte_en         : a header byte is accepted this cycle
//   in_byte, in_last: the byte and its end-of-file flag
//   img_*           : captured header fields (registered)
//   hdr_done        : header fully parsed (sticky until reset)
//   hdr_err         : sticky, bad magic or file ended inside header
//   hdr_complete    : combinational, byte 13 accepted this cycle
`ifdef QOI_HEADER_SKIP_EN
module qoi_hdr_parser
  import qoi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] img_width,
  output logic [31:0] img_height,
  output logic [7:0]  img_channels,
  output logic [7:0]  img_colorspace,
  output logic        hdr_done,
  output logic        hdr_err,
  output logic        hdr_complete
);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] width_q, width_d, height_q, height_d;
  logic [7:0]  chan_q, chan_d, cs_q, cs_d;
  logic        done_q, done_d, err_q, err_d;

  always_comb begin
    cnt_d        = cnt_q;
    width_d      = width_q;
    height_d     = height_q;
    chan_d       = chan_q;
    cs_d         = cs_q;
    done_d       = done_q;
    err_d        = err_q;
    hdr_complete = 1'b0;
    if (byte_en) begin
      if (in_last) begin
        // File ended inside the header: flag it and wait for a fresh header.
        err_d = 1'b1;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        case (cnt_q)
          4'd0, 4'd1, 4'd2, 4'd3:
            if (in_byte != QOI_MAGIC[cnt_q[1:0]]) err_d = 1'b1;
          4'd4, 4'd5, 4'd6, 4'd7:     width_d  = {width_q[23:0], in_byte};
          4'd8, 4'd9, 4'd10, 4'd11:   height_d = {height_q[23:0], in_byte};
          4'd12:                      chan_d   = in_byte;
          default: begin
            cs_d         = in_byte;
            done_d       = 1'b1;
            cnt_d        = 4'd0;
            hdr_complete = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      chan_q   <= '0;
      cs_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      height_q <= height_d;
      chan_q   <= chan_d;
      cs_q     <= cs_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign img_width      = width_q;
  assign img_height     = height_q;
  assign img_channels   = chan_q;
  assign img_colorspace = cs_q;
  assign hdr_done       = done_q;
  assign hdr_err        = err_q;

endmodule
`endif

// File: rtl/qoi_chunk_window.sv
// qoi_chunk_window: byte-stream front end for qoi_decoder. Buffers the
// compressed file in a DEPTH-byte shift window, presents the oldest 5 bytes
// as chunk[4:0] and drops the bytes the decoder reports consumed.
// Optional header stripping is built when QOI_HEADER_SKIP_EN is defined.
//   clk, rst                 : clock, synchronous active-high reset
//   in_byte/in_valid/in_last : input byte stream, in_ready back-pressure
//   chunk, chunk_avail       : window bytes (chunk[0] oldest), bytes held
//   chunk_valid              : window presentable to the decoder
//   chunk_len_consumed       : bytes consumed this cycle (0..5)
//   stream_done              : pulse when the last file byte leaves
//   underflow_err            : sticky, decoder consumed more than held
//   img_*, hdr_done, hdr_err : header fields and status
module qoi_chunk_window
  import qoi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [4:0][7:0] chunk,
  output logic [3:0]      chunk_avail,
  output logic            chunk_valid,
  input  logic [2:0]      chunk_len_consumed,
  output logic            stream_done,
  output logic            underflow_err,
  output logic [31:0]     img_width,
  output logic [31:0]     img_height,
  output logic [7:0]      img_channels,
  output logic [7:0]      img_colorspace,
  output logic            hdr_done,
  output logic            hdr_err
);

  localparam int         WW      = 8 * DEPTH;
  localparam logic [4:0] DEPTH_F = 5'(DEPTH);
`ifdef QOI_HEADER_SKIP_EN
  localparam qoi_state_e ST_ENTRY = ST_HDR;
`else
  localparam qoi_state_e ST_ENTRY = ST_STREAM;
`endif

  qoi_state_e    state_q, state_d;
  logic [4:0]    fill_q, fill_d;
  logic [WW-1:0] win_q, win_d;
  logic [3:0]    avail_q, avail_d;
  logic          done_q, done_d, uf_q, uf_d;
  logic          accept, to_win, uf_now, hdr_complete;
  logic [4:0]    len_ext, cons, wr_idx;

  // Handshake decodes registered state only; no path from the consume input.
  always_comb begin
    chunk_valid = 1'b0;
    case (state_q)
      ST_STREAM: chunk_valid = fill_q >= 5'(QOI_MAX_CHUNK);
      ST_DRAIN:  chunk_valid = fill_q != 5'd0;
      default:   chunk_valid = 1'b0;
    endcase
    in_ready = (fill_q < DEPTH_F) && (state_q != ST_DRAIN);
  end

  always_comb begin
    accept  = in_valid && in_ready;
    to_win  = accept && (state_q != ST_HDR);
    len_ext = {2'b00, chunk_len_consumed};
    uf_now  = chunk_valid && (len_ext > fill_q);
    // An over-consume drains exactly what is held, so fill_next == accept.
    cons    = !chunk_valid ? 5'd0 : (uf_now ? fill_q : len_ext);
    wr_idx  = fill_q - cons;

    // Shift down by cons bytes (zeros enter at the top so empty slots read 0),
    // then drop the new byte at the first free slot.
    win_d = win_q >> {cons, 3'b000};
    if (to_win) win_d = win_d | ({{(WW-8){1'b0}}, in_byte} << {wr_idx, 3'b000});

    fill_d  = fill_q - cons + {4'd0, to_win};
    avail_d = (fill_d > 5'd15) ? 4'hF : fill_d[3:0];
    uf_d    = uf_q | uf_now;

    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_HDR:    if (hdr_complete) state_d = ST_STREAM;
      ST_STREAM: if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (fill_d == 5'd0) begin
                   state_d = ST_ENTRY;
                   done_d  = 1'b1;
                 end
      default:   state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      fill_q  <= '0;
      win_q   <= '0;
      avail_q <= '0;
      done_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      avail_q <= avail_d;
      done_q  <= done_d;
      uf_q    <= uf_d;
    end
  end

  assign chunk         = win_q[39:0];
  assign chunk_avail   = avail_q;
  assign stream_done   = done_q;
  assign underflow_err = uf_q;

`ifdef QOI_HEADER_SKIP_EN
  qoi_hdr_parser u_hdr (
    .clk            (clk),
    .rst            (rst),
    .byte_en        (accept && (state_q == ST_HDR)),
    .in_byte        (in_byte),
    .in_last        (in_last),
    .img_width      (img_width),
    .img_height     (img_height),
    .img_channels   (img_channels),
    .img_colorspace (img_colorspace),
    .hdr_done       (hdr_done),
    .hdr_err        (hdr_err),
    .hdr_complete   (hdr_complete)
  );
`else
  assign img_width      = '0;
  assign img_height     = '0;
  assign img_channels   = '0;
  assign img_colorspace = '0;
  assign hdr_done       = 1'b1;
  assign hdr_err        = 1'b0;
  assign hdr_complete   = 1'b0;
`endif

endmodule

// File: tb/tb_qoi_chunk_window.sv
module tb_qoi_chunk_window;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_byte = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [4:0][7:0] chunk;
  logic [3:0]      chunk_avail;
  logic            chunk_valid;
  logic [2:0]      chunk_len_consumed = '0;
  logic            stream_done;
  logic            underflow_err;
  logic [31:0]     img_width, img_height;
  logic [7:0]      img_channels, img_colorspace;
  logic            hdr_done, hdr_err;

  always #5 clk = ~clk;

  qoi_chunk_window #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .chunk(chunk),
    .chunk_avail(chunk_avail), .chunk_valid(chunk_valid),
    .chunk_len_consumed(chunk_len_consumed), .stream_done(stream_done),
    .underflow_err(underflow_err), .img_width(img_width),
    .img_height(img_height), .img_channels(img_channels),
    .img_colorspace(img_colorspace), .hdr_done(hdr_done), .hdr_err(hdr_err)
  );

`ifdef QOI_HEADER_SKIP_EN
  localparam logic HD_RST = 1'b0;
`else
  localparam logic HD_RST = 1'b1;
`endif

  localparam int S_READY = 0, S_VALID = 1, S_AVAIL = 2, S_CHUNK = 3,
                 S_DONE = 4, S_UF = 5, S_W = 6, S_H = 7, S_CH = 8,
                 S_CS = 9, S_HDONE = 10, S_HERR = 11;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] val;
  } chk_t;

  chk_t       chk_q[$];   // status expectations, checked at the next negedge
  logic [7:0] byte_q[$];  // window byte order scoreboard
  int         n_chk = 0, n_fail = 0;
  int         done_exp = 0, done_seen = 0;
  logic       sb_en = 1'b1;
  logic       fin = 1'b0;

  function automatic logic [63:0] sig(input int sel);
    case (sel)
      S_READY: return {63'd0, in_ready};
      S_VALID: return {63'd0, chunk_valid};
      S_AVAIL: return {60'd0, chunk_avail};
      S_CHUNK: return {24'd0, chunk};
      S_DONE:  return {63'd0, stream_done};
      S_UF:    return {63'd0, underflow_err};
      S_W:     return {32'd0, img_width};
      S_H:     return {32'd0, img_height};
      S_CH:    return {56'd0, img_channels};
      S_CS:    return {56'd0, img_colorspace};
      S_HDONE: return {63'd0, hdr_done};
      default: return {63'd0, hdr_err};
    endcase
  endfunction

  // Monitor: sole owner of the comparison counters.
  initial begin
    chk_t       e;
    logic [63:0] act;
    logic [7:0]  exp_b;
    int          k;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        e   = chk_q.pop_front();
        act = sig(e.sel);
        n_chk++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
        end
      end
      if (!rst && chunk_valid && chunk_len_consumed != 0) begin
        k = (int'(chunk_len_consumed) < int'(chunk_avail)) ? int'(chunk_len_consumed) : int'(chunk_avail);
        for (int i = 0; i < k; i++) begin
          n_chk++;
          if (byte_q.size() == 0) begin
            n_fail++;
            $display("FAIL byte_order: consumed %0h with no byte expected", chunk[i]);
          end else begin
            exp_b = byte_q.pop_front();
            if (chunk[i] !== exp_b) begin
              n_fail++;
              $display("FAIL byte_order: got %0h, expected %0h", chunk[i], exp_b);
            end
          end
        end
      end
      if (!rst && stream_done) done_seen++;
      if (fin) begin
        n_chk++;
        if (byte_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover_bytes: got %0d unconsumed, expected 0", byte_q.size());
        end
        n_chk++;
        if (done_seen != done_exp) begin
          n_fail++;
          $display("FAIL done_count: got %0d pulses, expected %0d", done_seen, done_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic ex(input string name, input int sel, input logic [63:0] val);
    chk_t e;
    e.name = name; e.sel = sel; e.val = val;
    chk_q.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic l, input logic [2:0] c);
    in_valid = v; in_byte = b; in_last = l; chunk_len_consumed = c;
    if (v && sb_en) byte_q.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; chunk_len_consumed = 3'd0;
  endtask

  task automatic reset_checks();
    ex("rst_ready", S_READY, 1);   ex("rst_valid", S_VALID, 0);
    ex("rst_avail", S_AVAIL, 0);   ex("rst_chunk", S_CHUNK, 0);
    ex("rst_done", S_DONE, 0);     ex("rst_uf", S_UF, 0);
    ex("rst_width", S_W, 0);       ex("rst_height", S_H, 0);
    ex("rst_chan", S_CH, 0);       ex("rst_cs", S_CS, 0);
    ex("rst_hdone", S_HDONE, {63'd0, HD_RST});
    ex("rst_herr", S_HERR, 0);
  endtask

  task automatic send_hdr(input logic [7:0] first);
`ifdef QOI_HEADER_SKIP_EN
    logic [7:0] hb [0:13];
    hb = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h01, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h80, 8'h04, 8'h00};
    hb[0] = first;
    sb_en = 1'b0;
    for (int i = 0; i < 14; i++) cyc(1'b1, hb[i], 1'b0, 3'd0);
    sb_en = 1'b1;
`else
    sb_en = (first == 8'h71);
`endif
  endtask

  initial begin
    // Reset values checked while reset is still held.
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    reset_checks();
    cyc(0, 0, 0, 0);
    rst = 1'b0;

    send_hdr(8'h71);
`ifdef QOI_HEADER_SKIP_EN
    ex("hdr_width", S_W, 256);   ex("hdr_height", S_H, 128);
    ex("hdr_chan", S_CH, 4);     ex("hdr_cs", S_CS, 0);
    ex("hdr_done", S_HDONE, 1);  ex("hdr_err_ok", S_HERR, 0);
`endif

    // Window fills to 5 before presenting.
    cyc(1, 8'hFE, 0, 0); ex("t1_valid_1", S_VALID, 0);
    cyc(1, 8'h10, 0, 0); ex("t1_valid_2", S_VALID, 0);
    cyc(1, 8'h20, 0, 0); ex("t1_valid_3", S_VALID, 0);
    cyc(1, 8'h30, 0, 0); ex("t1_valid_4", S_VALID, 0);
    cyc(1, 8'h55, 0, 0);
    ex("t1_valid_5", S_VALID, 1); ex("t1_avail_5", S_AVAIL, 5);
    ex("t1_chunk_5", S_CHUNK, 64'h55_30_20_10_FE);
    cyc(0, 0, 0, 4);
    ex("t1_avail_c4", S_AVAIL, 1); ex("t1_chunk_c4", S_CHUNK, 64'h55);
    ex("t1_valid_c4", S_VALID, 0);

    // Simultaneous push and consume-5 at fill == 5.
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
    ex("t3_avail_pre", S_AVAIL, 5);
    cyc(1, 8'h99, 0, 5);
    ex("t3_avail", S_AVAIL, 1); ex("t3_chunk", S_CHUNK, 64'h99);

    // 32 bytes back-to-back, consume 1 per cycle, last byte ends the file.
    for (int i = 0; i < 32; i++) begin
      cyc(1, 8'hA0 + 8'(i), (i == 31), 1);
      if (i < 31) ex("t2_no_stall", S_READY, 1);
    end
    ex("t2_drain_ready", S_READY, 0); ex("t2_drain_valid", S_VALID, 1);
    ex("t2_drain_avail", S_AVAIL, 5);
    done_exp++;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    ex("t2_avail_1", S_AVAIL, 1); ex("t2_done_early", S_DONE, 0);
    cyc(0, 0, 0, 1);
    ex("t2_done", S_DONE, 1); ex("t2_avail_0", S_AVAIL, 0);
    ex("t2_valid_0", S_VALID, 0);
    cyc(0, 0, 0, 0);
    ex("t2_done_pulse", S_DONE, 0); ex("t2_entry_ready", S_READY, 1);

    // Short file: 3 bytes, consume 2 then 1.
    send_hdr(8'h71);
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 1, 0);
    ex("t4_valid", S_VALID, 1); ex("t4_avail", S_AVAIL, 3);
    ex("t4_ready", S_READY, 0); ex("t4_chunk", S_CHUNK, 64'h33_22_11);
    done_exp++;
    cyc(0, 0, 0, 2);
    ex("t4_avail_1", S_AVAIL, 1); ex("t4_chunk_1", S_CHUNK, 64'h33);
    ex("t4_done_early", S_DONE, 0);
    cyc(0, 0, 0, 1);
    ex("t4_done", S_DONE, 1); ex("t4_avail_0", S_AVAIL, 0);
    cyc(0, 0, 0, 0);
    ex("t4_done_pulse", S_DONE, 0); ex("t4_entry_ready", S_READY, 1);

    // Underflow in DRAIN: fill 2, decoder consumes 5.
    send_hdr(8'h71);
    cyc(1, 8'h44, 0, 0); cyc(1, 8'h66, 1, 0);
    ex("uf_valid", S_VALID, 1); ex("uf_pre", S_UF, 0);
    done_exp++;
    cyc(0, 0, 0, 5);
    ex("uf_set", S_UF, 1); ex("uf_avail", S_AVAIL, 0);
    ex("uf_done", S_DONE, 1); ex("uf_chunk", S_CHUNK, 0);
    cyc(0, 0, 0, 0);
    ex("uf_sticky", S_UF, 1); ex("uf_ready", S_READY, 1);

    // Reset mid-stream.
    send_hdr(8'h71);
    cyc(1, 8'h77, 0, 0); cyc(1, 8'h88, 0, 0);
    ex("mid_avail", S_AVAIL, 2);
    rst = 1'b1;
    byte_q.delete();
    cyc(0, 0, 0, 0);
    reset_checks();
    cyc(0, 0, 0, 0);
    rst = 1'b0;

`ifdef QOI_HEADER_SKIP_EN
    // Header then a single-byte body.
    send_hdr(8'h71);
    cyc(1, 8'hC3, 1, 0);
    ex("h_chunk", S_CHUNK, 64'hC3); ex("h_valid", S_VALID, 1);
    ex("h_hdone", S_HDONE, 1);      ex("h_width", S_W, 256);
    ex("h_height", S_H, 128);       ex("h_chan", S_CH, 4);
    done_exp++;
    cyc(0, 0, 0, 1);
    ex("h_done", S_DONE, 1);
    // Corrupted magic.
    rst = 1'b1; cyc(0, 0, 0, 0); rst = 1'b0;
    ex("h_err_clear", S_HERR, 0);
    send_hdr(8'h70);
    ex("h_err", S_HERR, 1);
`endif

    cyc(0, 0, 0, 0);
    fin = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL monitor_timeout: got no summary, expected one");
    $fatal(1, "monitor did not finish");
  end

endmodule
